// File: rtl/freq_sweep_engine.sv
// freq_sweep_engine
//   Sweep trajectory generator feeding the DDS phase-increment path. A signed
//   offset walks between -range and +range once per update tick. It can follow
//   a triangle or a sawtooth, with a programmable dwell at each endpoint and
//   one-shot or continuous operation. The output is base + offset, clamped to
//   [FREQ_MIN, FREQ_MAX] and registered. pulse_mode overrides the output with
//   PULSE_FREQ while the sweep keeps running underneath.
//   The sweep configuration is captured into shadow registers at sweep start.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   enable        level; 1 runs the sweep, 0 returns to IDLE
//   oneshot       captured at start; 1 = single cycle then DONE
//   sweep_mode    00 off, 01 triangle, 10 sawtooth, 11 off
//   base_freq     centre frequency (live, not shadowed)
//   sweep_range   deviation +/- range
//   sweep_speed   offset step per update tick
//   dwell         endpoint hold length in update ticks
//   pulse_mode    force current_freq to PULSE_FREQ
//   current_freq  registered clamped frequency
//   sweep_active  high in RISE / DWELL_HI / FALL / DWELL_LO
//   done          one-cycle pulse on entry to DONE
//   marker        (only with SWEEP_MARKER_EN) one-cycle pulse when the rising
//                 offset crosses from negative to non-negative
//
// Build option: define SWEEP_MARKER_EN to add the marker output.
module freq_sweep_engine #(
   parameter int FREQ_W     = 22,
   parameter int RANGE_W    = 17,
   parameter int SPEED_W    = 13,
   parameter int DWELL_W    = 10,
   parameter int UPDATE_DIV = 100000,
   parameter int FREQ_MIN   = 1000,
   parameter int FREQ_MAX   = 999000,
   parameter int PULSE_FREQ = 3000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               oneshot,
   input  logic [1:0]         sweep_mode,
   input  logic [FREQ_W-1:0]  base_freq,
   input  logic [RANGE_W-1:0] sweep_range,
   input  logic [SPEED_W-1:0] sweep_speed,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               pulse_mode,
   output logic [FREQ_W-1:0]  current_freq,
   output logic               sweep_active,
`ifdef SWEEP_MARKER_EN
   output logic               marker,
`endif
   output logic               done
);

   localparam int OFS_W = RANGE_W + 2;
   localparam int SUM_W = FREQ_W + 2;
   localparam int CNT_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
   localparam logic [FREQ_W-1:0]       RESET_FREQ = FREQ_W'(100000);
   localparam logic [FREQ_W-1:0]       PULSE_VAL  = FREQ_W'(PULSE_FREQ);
   localparam logic [FREQ_W-1:0]       MIN_VAL    = FREQ_W'(FREQ_MIN);
   localparam logic [FREQ_W-1:0]       MAX_VAL    = FREQ_W'(FREQ_MAX);
   localparam logic signed [SUM_W-1:0] MIN_S      = SUM_W'(FREQ_MIN);
   localparam logic signed [SUM_W-1:0] MAX_S      = SUM_W'(FREQ_MAX);
   localparam logic [CNT_W-1:0]        CNT_LAST   = CNT_W'(UPDATE_DIV - 1);

   typedef enum logic [2:0] {IDLE, RISE, DWELL_HI, FALL, DWELL_LO, DONE} state_t;

   state_t                  state_reg, state_next;
   logic signed [OFS_W-1:0] offset_reg, offset_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic [DWELL_W-1:0]      dcnt_reg, dcnt_next;
   logic [RANGE_W-1:0]      range_sh;
   logic [SPEED_W-1:0]      speed_sh;
   logic [DWELL_W-1:0]      dwell_sh;
   logic [1:0]              mode_sh;
   logic                    oneshot_sh;
   logic                    capture;
   logic                    tick;
   logic                    done_reg;
   logic signed [OFS_W-1:0] range_s, speed_s, range_in_s;
   logic signed [SUM_W-1:0] sum;
   logic [FREQ_W-1:0]       freq_next;

   // Zero-extended operands; the two spare offset bits keep offset +/- speed
   // from overflowing.
   assign range_s    = $signed({2'b00, range_sh});
   assign range_in_s = $signed({2'b00, sweep_range});
   assign speed_s    = $signed({{(OFS_W-SPEED_W){1'b0}}, speed_sh});
   assign tick       = (cnt_reg == CNT_LAST);

   always_comb begin
      state_next  = state_reg;
      offset_next = offset_reg;
      dcnt_next   = dcnt_reg;
      cnt_next    = tick ? '0 : cnt_reg + CNT_W'(1);
      capture     = 1'b0;
      if (!enable) begin
         state_next  = IDLE;
         offset_next = '0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               offset_next = '0;
               if (sweep_mode == 2'b01 || sweep_mode == 2'b10) begin
                  capture     = 1'b1;
                  offset_next = -range_in_s;
                  state_next  = RISE;
                  // Restarting the divider puts the first step exactly
                  // UPDATE_DIV cycles after start.
                  cnt_next    = '0;
               end
            end
            RISE: if (tick) begin
               if (offset_reg + speed_s >= range_s) begin
                  offset_next = range_s;
                  state_next  = DWELL_HI;
                  dcnt_next   = '0;
               end else begin
                  offset_next = offset_reg + speed_s;
               end
            end
            // Dwell exits on the tick after dwell ticks have been counted,
            // so dwell = 0 leaves on the first tick.
            DWELL_HI: if (tick) begin
               if (dcnt_reg == dwell_sh) begin
                  dcnt_next = '0;
                  if (mode_sh == 2'b10) begin
                     offset_next = -range_s;
                     state_next  = DWELL_LO;
                  end else begin
                     state_next  = FALL;
                  end
               end else begin
                  dcnt_next = dcnt_reg + DWELL_W'(1);
               end
            end
            FALL: if (tick) begin
               if (offset_reg - speed_s <= -range_s) begin
                  offset_next = -range_s;
                  state_next  = DWELL_LO;
                  dcnt_next   = '0;
               end else begin
                  offset_next = offset_reg - speed_s;
               end
            end
            DWELL_LO: if (tick) begin
               if (dcnt_reg == dwell_sh) begin
                  dcnt_next  = '0;
                  state_next = oneshot_sh ? DONE : RISE;
               end else begin
                  dcnt_next = dcnt_reg + DWELL_W'(1);
               end
            end
            DONE: offset_next = -range_s;
            default: begin
               state_next  = IDLE;
               offset_next = '0;
            end
         endcase
      end
   end

   // Output stage: base + offset, clamped; pulse override wins.
   assign sum = $signed({2'b00, base_freq}) +
                $signed({{(SUM_W-OFS_W){offset_reg[OFS_W-1]}}, offset_reg});

   always_comb begin
      if (pulse_mode)
         freq_next = PULSE_VAL;
      else if (sum < MIN_S)
         freq_next = MIN_VAL;
      else if (sum > MAX_S)
         freq_next = MAX_VAL;
      else
         freq_next = sum[FREQ_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         offset_reg   <= '0;
         cnt_reg      <= '0;
         dcnt_reg     <= '0;
         range_sh     <= '0;
         speed_sh     <= '0;
         dwell_sh     <= '0;
         mode_sh      <= 2'b00;
         oneshot_sh   <= 1'b0;
         current_freq <= RESET_FREQ;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         offset_reg   <= offset_next;
         cnt_reg      <= cnt_next;
         dcnt_reg     <= dcnt_next;
         if (capture) begin
            range_sh   <= sweep_range;
            speed_sh   <= sweep_speed;
            dwell_sh   <= dwell;
            mode_sh    <= sweep_mode;
            oneshot_sh <= oneshot;
         end
         current_freq <= freq_next;
         done_reg     <= (state_next == DONE) && (state_reg != DONE);
      end
   end

   assign done         = done_reg;
   assign sweep_active = (state_reg == RISE) || (state_reg == DWELL_HI) ||
                         (state_reg == FALL) || (state_reg == DWELL_LO);

`ifdef SWEEP_MARKER_EN
   logic marker_reg;

   // Only a rising step can cross zero upward; the sawtooth jump goes to
   // -range and FALL only moves down. enable guards the forced return to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         marker_reg <= 1'b0;
      else
         marker_reg <= enable && (state_reg == RISE) && tick &&
                       offset_reg[OFS_W-1] && !offset_next[OFS_W-1];
   end

   assign marker = marker_reg;
`endif

endmodule

// File: tb/tb_freq_sweep_engine.sv
module tb_freq_sweep_engine;

   localparam int DIV      = 10;
   localparam int FMIN     = 1000;
   localparam int FMAX     = 999000;
   localparam int PULSE    = 3000000;
   localparam int RST_FREQ = 100000;
   localparam int P_IDLE = 0, P_RISE = 1, P_DHI = 2, P_FALL = 3, P_DLO = 4, P_DONE = 5;
   localparam int S_END  = 99;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        oneshot;
   logic [1:0]  sweep_mode;
   logic [21:0] base_freq;
   logic [16:0] sweep_range;
   logic [12:0] sweep_speed;
   logic [9:0]  dwell;
   logic        pulse_mode;
   logic [21:0] current_freq;
   logic        sweep_active;
   logic        done;
`ifdef SWEEP_MARKER_EN
   logic        marker;
`endif

   freq_sweep_engine #(.UPDATE_DIV(DIV)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .oneshot      (oneshot),
      .sweep_mode   (sweep_mode),
      .base_freq    (base_freq),
      .sweep_range  (sweep_range),
      .sweep_speed  (sweep_speed),
      .dwell        (dwell),
      .pulse_mode   (pulse_mode),
      .current_freq (current_freq),
      .sweep_active (sweep_active),
`ifdef SWEEP_MARKER_EN
      .marker       (marker),
`endif
      .done         (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [21:0] freq;
      logic        act;
      logic        dn;
      logic        mk;
   } exp_t;

   exp_t sb[$];
   int   scen_id;

   // ---------------- reference model (driver side) ----------------
   // Phase plus cycles-since-start; ticks fall on every DIV-th cycle of the
   // sweep, dwell is "ticks left before leaving".
   int m_phase, m_ofs, m_cyc, m_left;
   int sh_rng, sh_spd, sh_dw;
   bit sh_saw, sh_os;

   task automatic model_reset();
      m_phase = P_IDLE;
      m_ofs   = 0;
      m_cyc   = 0;
      m_left  = 0;
   endtask

   function automatic int clampf(input int v);
      if (v < FMIN) return FMIN;
      if (v > FMAX) return FMAX;
      return v;
   endfunction

   task automatic model_step();
      exp_t e;
      int   old_ofs, old_phase;
      bit   tk;
      if (rst) begin
         model_reset();
         e = '{freq: 22'(RST_FREQ), act: 1'b0, dn: 1'b0, mk: 1'b0};
         sb.push_back(e);
         return;
      end
      e.freq    = pulse_mode ? 22'(PULSE) : 22'(clampf(int'(base_freq) + m_ofs));
      tk        = (m_phase != P_IDLE) && ((m_cyc % DIV) == DIV - 1);
      old_ofs   = m_ofs;
      old_phase = m_phase;
      if (!enable) begin
         m_phase = P_IDLE;
         m_ofs   = 0;
      end else begin
         case (m_phase)
            P_IDLE: if (sweep_mode == 2'd1 || sweep_mode == 2'd2) begin
               sh_rng  = int'(sweep_range);
               sh_spd  = int'(sweep_speed);
               sh_dw   = int'(dwell);
               sh_saw  = (sweep_mode == 2'd2);
               sh_os   = oneshot;
               m_ofs   = -sh_rng;
               m_phase = P_RISE;
            end
            P_RISE: if (tk) begin
               if (m_ofs + sh_spd >= sh_rng) begin
                  m_ofs = sh_rng; m_phase = P_DHI; m_left = sh_dw;
               end else m_ofs = m_ofs + sh_spd;
            end
            P_DHI: if (tk) begin
               if (m_left == 0) begin
                  if (sh_saw) begin
                     m_ofs = -sh_rng; m_phase = P_DLO; m_left = sh_dw;
                  end else m_phase = P_FALL;
               end else m_left--;
            end
            P_FALL: if (tk) begin
               if (m_ofs - sh_spd <= -sh_rng) begin
                  m_ofs = -sh_rng; m_phase = P_DLO; m_left = sh_dw;
               end else m_ofs = m_ofs - sh_spd;
            end
            P_DLO: if (tk) begin
               if (m_left == 0) m_phase = sh_os ? P_DONE : P_RISE;
               else m_left--;
            end
            default: ;
         endcase
      end
      m_cyc  = (old_phase == P_IDLE) ? 0 : m_cyc + 1;
      e.act  = (m_phase >= P_RISE) && (m_phase <= P_DLO);
      e.dn   = (m_phase == P_DONE) && (old_phase != P_DONE);
      e.mk   = enable && (old_phase == P_RISE) && tk && (old_ofs < 0) && (m_ofs >= 0);
      sb.push_back(e);
   endtask

   task automatic cycle();
      model_step();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic cfg(input int b, input int r, input int s, input int d,
                      input int m, input bit os);
      base_freq   = 22'(b);
      sweep_range = 17'(r);
      sweep_speed = 13'(s);
      dwell       = 10'(d);
      sweep_mode  = 2'(m);
      oneshot     = os;
   endtask

   // Close a scenario: drop enable on the old base, then switch the scenario
   // id together with the new configuration.
   task automatic next_scen(input int id, input int b, input int r, input int s,
                            input int d, input int m, input bit os);
      enable     = 1'b0;
      pulse_mode = 1'b0;
      run(3);
      scen_id = id;
      cfg(b, r, s, d, m, os);
      run(2);
      enable = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin : driver
      int guard;
      scen_id = 0;
      rst = 1'b0;
      enable = 1'b0;
      pulse_mode = 1'b0;
      cfg(100000, 0, 0, 0, 0, 1'b0);
      model_reset();
      #2 rst = 1'b1;
      @(negedge clk);
      cycle();
      rst = 1'b0;
      run(3);

      // 1: continuous triangle
      next_scen(1, 100000, 5000, 1000, 2, 1, 1'b0);
      run(600);
      // 2: sawtooth, dwell 0
      next_scen(2, 100000, 3000, 2000, 0, 2, 1'b0);
      run(200);
      // 3: clamp at the low end
      next_scen(3, 2000, 5000, 5000, 0, 1, 1'b0);
      run(100);
      // 4: pulse override on top of the running sweep
      scen_id = 4;
      pulse_mode = 1'b1;
      run(8);
      pulse_mode = 1'b0;
      run(30);
      // 5: oneshot triangle
      next_scen(5, 100000, 2000, 1000, 1, 1, 1'b1);
      run(200);
`ifdef SWEEP_MARKER_EN
      // 6: marker at the rising zero crossing
      next_scen(6, 100000, 4000, 1000, 0, 1, 1'b0);
      run(300);
`endif
      // 7: shadowing, enable drop, asynchronous reset mid-FALL
      next_scen(7, 100000, 5000, 1000, 1, 1, 1'b0);
      run(25);
      sweep_speed = 13'd3000;
      sweep_mode  = 2'd2;
      sweep_range = 17'd9000;
      run(60);
      enable = 1'b0;
      run(3);
      sweep_mode = 2'd1;
      enable = 1'b1;
      guard = 0;
      while (m_phase != P_FALL && guard < 2000) begin
         cycle();
         guard++;
      end
      run(7);
      rst = 1'b1;
      #2;
      model_reset();
      cycle();
      rst = 1'b0;
      run(40);
      // 8: randomized sweeps with mid-sweep register churn
      next_scen(8, 100000, 0, 0, 0, 0, 1'b0);
      for (int r = 0; r < 8; r++) begin
         cfg(int'($urandom_range(0, 1100000)),
             (r == 0) ? 0 : int'($urandom_range(0, 8000)),
             (r == 1) ? 0 : int'($urandom_range(0, 3000)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
         enable = 1'b1;
         for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 19) == 0)
               cfg(int'(base_freq), int'($urandom_range(0, 8000)),
                   int'($urandom_range(0, 3000)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 39) == 0) pulse_mode = ~pulse_mode;
            if ($urandom_range(0, 149) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 2) == 0) enable = 1'b1;
            cycle();
         end
         enable = 1'b0;
         pulse_mode = 1'b0;
         run(3);
      end
      scen_id = S_END;
      repeat (6) @(negedge clk);
      $display("FAIL watchdog actual=no_summary required=summary");
      $fatal(1, "monitor did not finish");
   end

   // ---------------- monitor / scoreboard ----------------
   int checks, failures;
   int mon_last;
   int obs_max, obs_min, done_cnt, done_freq, pulse_cnt, mk_cnt, dec2k, dec6k;
   int prev_freq;
   bit prev_valid;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      obs_max = 0; obs_min = 32'h7fffffff; done_cnt = 0; done_freq = -1;
      pulse_cnt = 0; mk_cnt = 0; dec2k = 0; dec6k = 0; prev_valid = 1'b0;
   endtask

   task automatic end_scenario(input int id);
      case (id)
         1: begin chk("tri_max", obs_max, 105000); chk("tri_min", obs_min, 95000); end
         2: begin
            chk("saw_max", obs_max, 103000); chk("saw_min", obs_min, 97000);
            chk("saw_descending_steps", dec2k, 0); chk("saw_jump_seen", int'(dec6k > 0), 1);
         end
         3: begin chk("clamp_min", obs_min, 1000); chk("clamp_max", obs_max, 7000); end
         4: chk("pulse_cycles", pulse_cnt, 8);
         5: begin
            chk("oneshot_done_pulses", done_cnt, 1); chk("oneshot_done_freq", done_freq, 98000);
            chk("oneshot_min", obs_min, 98000);
         end
         6: chk("marker_pulses", mk_cnt, 2);
         default: ;
      endcase
      if (id != 0) $display("scenario %0d closed checks=%0d", id, checks);
   endtask

   initial begin : monitor
      exp_t e;
      int   f;
      checks = 0; failures = 0; mon_last = 0;
      clear_stats();
      forever begin
         @(posedge clk or posedge rst);
         #1;
         if (scen_id != mon_last) begin
            end_scenario(mon_last);
            clear_stats();
            mon_last = scen_id;
            if (scen_id == S_END) begin
               chk("scoreboard_drained", sb.size(), 0);
               $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
               $finish;
            end
         end
         if (rst && !clk) begin
            chk("rst_freq", int'(current_freq), RST_FREQ);
            chk("rst_active", int'(sweep_active), 0);
            chk("rst_done", int'(done), 0);
         end else if (sb.size() > 0) begin
            e = sb.pop_front();
            f = int'(current_freq);
            chk("freq", f, int'(e.freq));
            chk("active", int'(sweep_active), int'(e.act));
            chk("done", int'(done), int'(e.dn));
`ifdef SWEEP_MARKER_EN
            chk("marker", int'(marker), int'(e.mk));
            if (marker) mk_cnt++;
`endif
            if (f > obs_max) obs_max = f;
            if (f < obs_min) obs_min = f;
            if (done) begin done_cnt++; done_freq = f; end
            if (f == PULSE) pulse_cnt++;
            if (prev_valid) begin
               if (prev_freq - f == 2000) dec2k++;
               if (prev_freq - f == 6000) dec6k++;
            end
            prev_freq  = f;
            prev_valid = 1'b1;
         end
      end
   end

endmodule
